// File: rtl/alsu_cmd_sched.sv
// Two-port command scheduler for one ALSU; response 3 cycles after accept (3+count for shift/rotate).
// Grants only from IDLE, one command in flight; response is held until rsp_ready.
module alsu_cmd_sched #(
    parameter string ARB_MODE = "RR"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [16:0] req0_cmd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [16:0] req1_cmd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  rsp_data,
    output logic        rsp_err,
    output logic        rsp_id,
    output logic        busy,
    output logic [2:0]  alsu_a,
    output logic [2:0]  alsu_b,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_direction,
    output logic        alsu_red_op_a,
    output logic        alsu_red_op_b,
    output logic        alsu_bypass_a,
    output logic        alsu_bypass_b,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds
);

    typedef struct packed {
        logic       red_b;
        logic       red_a;
        logic [2:0] count;
        logic       direction;
        logic       serial_in;
        logic       cin;
        logic [2:0] opcode;
        logic [2:0] b;
        logic [2:0] a;
    } cmd_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam bit FIXED_PRIO = (ARB_MODE == "FIXED0");

    logic [2:0] state;
    logic [2:0] remaining;
    cmd_t       cmd_q;
    cmd_t       gnt_cmd;
    logic       cur_id;
    logic       last_grant;
    logic       gnt_vld;
    logic       gnt_id;

    function automatic logic is_shift(input logic [2:0] op);
        return op[2:1] == 2'b10;
    endfunction

    // Grant is held off while rst is high so ready reads 0 throughout reset.
    always_comb begin
        gnt_vld = (state == S_IDLE) && !rst && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            gnt_id = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else begin
            gnt_id = req1_valid;
        end
        gnt_cmd = gnt_id ? cmd_t'(req1_cmd) : cmd_t'(req0_cmd);
    end

    assign req0_ready = gnt_vld && !gnt_id;
    assign req1_ready = gnt_vld && gnt_id;
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= 3'd0;
            cmd_q      <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
            rsp_data   <= 6'd0;
            rsp_err    <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        cmd_q      <= gnt_cmd;
                        cur_id     <= gnt_id;
                        last_grant <= gnt_id;
                        state      <= is_shift(gnt_cmd.opcode) ? S_LOAD : S_EXEC;
                    end
                end
                S_LOAD: begin
                    remaining <= cmd_q.count;
                    state     <= (cmd_q.count != 3'd0) ? S_EXEC : S_CAPT;
                end
                S_EXEC: begin
                    if (!is_shift(cmd_q.opcode) || (remaining == 3'd1)) begin
                        state <= S_CAPT;
                    end else begin
                        remaining <= remaining - 3'd1;
                    end
                end
                S_CAPT: begin
                    rsp_data <= alsu_out;
                    rsp_err  <= |alsu_leds;
                    rsp_id   <= cur_id;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // LOAD seeds the ALSU output register with A so shifts never see stale data.
    always_comb begin
        alsu_a         = 3'd0;
        alsu_b         = 3'd0;
        alsu_opcode    = 3'd0;
        alsu_cin       = 1'b0;
        alsu_serial_in = 1'b0;
        alsu_direction = 1'b0;
        alsu_red_op_a  = 1'b0;
        alsu_red_op_b  = 1'b0;
        alsu_bypass_a  = 1'b0;
        alsu_bypass_b  = 1'b0;
        case (state)
            S_LOAD: begin
                alsu_bypass_a = 1'b1;
                alsu_a        = cmd_q.a;
            end
            S_EXEC: begin
                alsu_a         = cmd_q.a;
                alsu_b         = cmd_q.b;
                alsu_opcode    = cmd_q.opcode;
                alsu_cin       = cmd_q.cin;
                alsu_serial_in = cmd_q.serial_in;
                alsu_direction = cmd_q.direction;
                alsu_red_op_a  = cmd_q.red_a;
                alsu_red_op_b  = cmd_q.red_b;
            end
            default: ;
        endcase
    end

endmodule
